// File: rtl/pcie_tx_credit_gate.sv
// Transmit flow-control gate: tracks per-(vc,type) credit limits and consumed
// credits, and grants a TLP only when PCIe modular credit arithmetic allows it.
module pcie_tx_credit_gate #(
  parameter int NUM_VC           = 1,
  parameter int HDR_CREDIT_DEPTH = 8,
  parameter int CREDIT_DEPTH     = 12,
  parameter int MAX_PAYLOAD_SIZE = 128,
  parameter int STALL_TIMEOUT    = 1024,
  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [VC_W-1:0]                       req_vc_i,
  input  logic [1:0]                            req_type_i,
  input  logic [10:0]                           req_len_dw_i,
  output logic                                  grant_o,
  output logic                                  err_o,
  input  logic                                  cl_valid_i,
  input  logic [VC_W-1:0]                       cl_vc_i,
  input  logic [1:0]                            cl_type_i,
  input  logic [HDR_CREDIT_DEPTH-1:0]           cl_hdr_i,
  input  logic [CREDIT_DEPTH-1:0]               cl_data_i,
  output logic                                  stall_o,
  output logic [NUM_VC*3*HDR_CREDIT_DEPTH-1:0]  cc_hdr_flat_o,
  output logic [NUM_VC*3*CREDIT_DEPTH-1:0]      cc_data_flat_o
);

  localparam int NE         = NUM_VC * 3;
  localparam int IDX_W      = $clog2(NE);
  localparam int HW         = HDR_CREDIT_DEPTH;
  localparam int DW         = CREDIT_DEPTH;
  localparam int MAX_LEN_DW = MAX_PAYLOAD_SIZE / 4;
  localparam int CNT_W      = $clog2(STALL_TIMEOUT + 1);
  localparam logic [HW-1:0] HDR_HALF  = HW'(1) << (HW - 1);
  localparam logic [DW-1:0] DATA_HALF = DW'(1) << (DW - 1);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, GRANT} state_t;
  state_t state_reg, state_next;

  logic [HW-1:0]    cl_hdr_reg  [NE];
  logic [HW-1:0]    cc_hdr_reg  [NE];
  logic [DW-1:0]    cl_data_reg [NE];
  logic [DW-1:0]    cc_data_reg [NE];
  logic [NE-1:0]    init_reg, hdr_inf_reg, data_inf_reg;
  logic [VC_W-1:0]  req_vc_reg;
  logic [1:0]       req_type_reg;
  logic [10:0]      req_len_reg;
  logic [CNT_W-1:0] blocked_cnt_reg;

  logic [4:0]       req_idx_raw, cl_idx_raw;
  logic             req_idx_ok, cl_idx_ok;
  logic [IDX_W-1:0] req_idx, cl_idx;
  logic [11:0]      len_ceil;
  logic [DW-1:0]    data_need, data_sum, data_gap;
  logic [HW-1:0]    hdr_sum, hdr_gap;
  logic             hdr_ok, data_ok, sufficient, bad_req;

  // Type 3 and VC numbers beyond NUM_VC do not map to any credit entry.
  assign req_idx_raw = 5'(req_vc_reg) * 5'd3 + 5'(req_type_reg);
  assign req_idx_ok  = (req_type_reg != 2'd3) && (req_idx_raw < 5'(NE));
  assign req_idx     = req_idx_ok ? req_idx_raw[IDX_W-1:0] : '0;
  assign cl_idx_raw  = 5'(cl_vc_i) * 5'd3 + 5'(cl_type_i);
  assign cl_idx_ok   = (cl_type_i != 2'd3) && (cl_idx_raw < 5'(NE));
  assign cl_idx      = cl_idx_ok ? cl_idx_raw[IDX_W-1:0] : '0;

  assign len_ceil  = (12'(req_len_reg) + 12'd3) >> 2;
  assign data_need = (req_type_reg == 2'd1) ? '0 : DW'(len_ceil);
  assign hdr_sum   = cc_hdr_reg[req_idx] + HW'(1);
  assign data_sum  = cc_data_reg[req_idx] + data_need;
  assign hdr_gap   = cl_hdr_reg[req_idx] - hdr_sum;
  assign data_gap  = cl_data_reg[req_idx] - data_sum;
  assign hdr_ok    = hdr_inf_reg[req_idx] || (hdr_gap <= HDR_HALF);
  assign data_ok   = data_inf_reg[req_idx] || (data_gap <= DATA_HALF);
  assign sufficient = req_idx_ok && init_reg[req_idx] && hdr_ok && data_ok;
  assign bad_req   = !req_idx_ok ||
                     ((req_type_reg != 2'd1) && (req_len_reg > 11'(MAX_LEN_DW)));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (req_valid_i) state_next = CHECK;
      CHECK: begin
        if (bad_req)         state_next = IDLE;
        else if (sufficient) state_next = GRANT;
        else                 state_next = WAIT;
      end
      WAIT:  if (sufficient) state_next = GRANT;
      GRANT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o = (state_reg == IDLE);
  assign grant_o     = (state_reg == GRANT);
  assign err_o       = (state_reg == CHECK) && bad_req;
  assign stall_o     = (blocked_cnt_reg >= CNT_W'(STALL_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      blocked_cnt_reg <= '0;
      init_reg        <= '0;
      hdr_inf_reg     <= '0;
      data_inf_reg    <= '0;
      req_vc_reg      <= '0;
      req_type_reg    <= '0;
      req_len_reg     <= '0;
      for (int i = 0; i < NE; i++) begin
        cl_hdr_reg[i]  <= '0;
        cc_hdr_reg[i]  <= '0;
        cl_data_reg[i] <= '0;
        cc_data_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && req_valid_i) begin
        req_vc_reg   <= req_vc_i;
        req_type_reg <= req_type_i;
        req_len_reg  <= req_len_dw_i;
      end
      // The first update of an entry is its InitFC; zero fields mean infinite.
      if (cl_valid_i && cl_idx_ok) begin
        cl_hdr_reg[cl_idx]  <= cl_hdr_i;
        cl_data_reg[cl_idx] <= cl_data_i;
        if (!init_reg[cl_idx]) begin
          init_reg[cl_idx]     <= 1'b1;
          hdr_inf_reg[cl_idx]  <= (cl_hdr_i == '0);
          data_inf_reg[cl_idx] <= (cl_data_i == '0);
        end
      end
      if (state_reg == GRANT) begin
        if (!hdr_inf_reg[req_idx])  cc_hdr_reg[req_idx]  <= hdr_sum;
        if (!data_inf_reg[req_idx]) cc_data_reg[req_idx] <= data_sum;
      end
      if (state_next == GRANT)
        blocked_cnt_reg <= '0;
      else if ((state_reg == WAIT) && (blocked_cnt_reg < CNT_W'(STALL_TIMEOUT)))
        blocked_cnt_reg <= blocked_cnt_reg + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NE; gi++) begin : g_flat
    assign cc_hdr_flat_o[gi*HW +: HW]  = cc_hdr_reg[gi];
    assign cc_data_flat_o[gi*DW +: DW] = cc_data_reg[gi];
  end

endmodule
